// File: rtl/ri_type.sv
// ri_type: RV32I R/I-type integer ALU with a registered result (one-cycle latency).
module ri_type (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [5:0]  aluSelect,
   output logic [31:0] result
);
   logic [31:0] result_d, result_q;
   logic [4:0]  sh;
   assign sh = b[4:0];
   // R-type and I-type codes share each datapath; unlisted codes fall to zero
   always_comb begin
      result_d = 32'h0;
      case (aluSelect)
         6'h13, 6'h1C: result_d = a + b;
         6'h1D:        result_d = a - b;
         6'h14, 6'h1E: result_d = a & b;
         6'h15, 6'h1F: result_d = a | b;
         6'h16, 6'h20: result_d = a ^ b;
         6'h17, 6'h21: result_d = a << sh;
         6'h18, 6'h22: result_d = a >> sh;
         6'h19, 6'h23: result_d = $unsigned($signed(a) >>> sh);
         6'h1A, 6'h24: result_d = {31'h0, $signed(a) < $signed(b)};
         6'h1B, 6'h25: result_d = {31'h0, a < b};
         default:      result_d = 32'h0;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) result_q <= 32'h0;
      else       result_q <= result_d;
   assign result = result_q;
endmodule

// File: tb/tb_ri_type.sv
// tb_ri_type: scoreboard bench for ri_type using directed vectors with hand-computed results.
module tb_ri_type;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] a, b, result;
   logic [5:0]  sel;
   int checks = 0;
   int passes = 0;
   typedef struct {
      string       name;
      logic [5:0]  sel;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[$];
   vec_t exp_q[$];
   vec_t m;
   vec_t w;
   ri_type dut (.clk(clk), .reset(reset), .a(a), .b(b), .aluSelect(sel), .result(result));
   always #5 clk = ~clk;
   task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", n, act, exp);
   endtask
   task automatic add(input string n, input logic [5:0] s, input logic [31:0] x,
                      input logic [31:0] y, input logic [31:0] e);
      vec_t v;
      v.name = n; v.sel = s; v.a = x; v.b = y; v.exp = e;
      vecs.push_back(v);
   endtask
   // monitor: each popped expectation belongs to inputs sampled one edge earlier
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         m = exp_q.pop_front();
         check(m.name, result, m.exp);
      end
   end
   initial begin
      add("addi", 6'h13, 32'hF0, 32'hF, 32'hFF);
      add("andi", 6'h14, 32'hF0, 32'hF, 32'h0);
      add("ori", 6'h15, 32'hF0, 32'hF, 32'hFF);
      add("xori", 6'h16, 32'hF0, 32'hF, 32'hFF);
      add("slli", 6'h17, 32'hF0, 32'hF, 32'h0078_0000);
      add("srli", 6'h18, 32'hF0, 32'hF, 32'h0);
      add("srai", 6'h19, 32'hF0, 32'hF, 32'h0);
      add("slti", 6'h1A, 32'hF0, 32'hF, 32'h0);
      add("sltiu", 6'h1B, 32'hF0, 32'hF, 32'h0);
      add("add", 6'h1C, 32'hF0, 32'hF, 32'hFF);
      add("sub", 6'h1D, 32'hF0, 32'hF, 32'hE1);
      add("and", 6'h1E, 32'hF0, 32'hF, 32'h0);
      add("or", 6'h1F, 32'hF0, 32'hF, 32'hFF);
      add("xor", 6'h20, 32'hF0, 32'hF, 32'hFF);
      add("sll", 6'h21, 32'hF0, 32'hF, 32'h0078_0000);
      add("srl", 6'h22, 32'hF0, 32'hF, 32'h0);
      add("sra", 6'h23, 32'hF0, 32'hF, 32'h0);
      add("slt", 6'h24, 32'hF0, 32'hF, 32'h0);
      add("sltu", 6'h25, 32'hF0, 32'hF, 32'h0);
      add("def_3f", 6'h3F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
      add("def_00", 6'h00, 32'hFFFF_FFFF, 32'h1, 32'h0);
      add("def_26", 6'h26, 32'hF0, 32'hF, 32'h0);
      add("def_12", 6'h12, 32'h1234_5678, 32'h1, 32'h0);
      add("srai_31", 6'h19, 32'h8000_0000, 32'h1F, 32'hFFFF_FFFF);
      add("sra_31", 6'h23, 32'h8000_0000, 32'h1F, 32'hFFFF_FFFF);
      add("srli_31", 6'h18, 32'h8000_0000, 32'h1F, 32'h1);
      add("srl_31", 6'h22, 32'h8000_0000, 32'h1F, 32'h1);
      add("slli_b21", 6'h17, 32'h8000_0000, 32'h21, 32'h0);
      add("sll_b21", 6'h21, 32'h8000_0000, 32'h21, 32'h0);
      add("sra_zero", 6'h23, 32'h8000_0000, 32'h0, 32'h8000_0000);
      add("srai_b24", 6'h19, 32'h8000_0000, 32'h24, 32'hF800_0000);
      add("slti_min", 6'h1A, 32'h8000_0000, 32'h1, 32'h1);
      add("slt_min", 6'h24, 32'h8000_0000, 32'h1, 32'h1);
      add("sltiu_min", 6'h1B, 32'h8000_0000, 32'h1, 32'h0);
      add("sltu_min", 6'h25, 32'h8000_0000, 32'h1, 32'h0);
      add("slt_eq", 6'h24, 32'h1234_5678, 32'h1234_5678, 32'h0);
      add("sltu_eq", 6'h25, 32'h1234_5678, 32'h1234_5678, 32'h0);
      add("sltiu_lt", 6'h1B, 32'h1, 32'h8000_0000, 32'h1);
      add("slt_negs", 6'h24, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0);
      add("sub_wrap", 6'h1D, 32'h0, 32'h1, 32'hFFFF_FFFF);
      reset = 1'b0; a = 32'h5; b = 32'h1; sel = 6'h1C;
      @(posedge clk); @(posedge clk);
      #2 check("pre_reset_add", result, 32'h6);
      #1 reset = 1'b1;
      #1 check("async_reset", result, 32'h0);
      a = 32'hFFFF_FFFF;
      repeat (2) @(posedge clk);
      #1 check("reset_hold", result, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      w.name = "wrap_add"; w.sel = sel; w.a = a; w.b = b; w.exp = 32'h0;
      exp_q.push_back(w);
      foreach (vecs[i]) begin
         @(negedge clk);
         a = vecs[i].a; b = vecs[i].b; sel = vecs[i].sel;
         exp_q.push_back(vecs[i]);
      end
      for (int n = 0; n < 20 && exp_q.size() > 0; n++) begin
         @(posedge clk);
         #2;
      end
      if (exp_q.size() > 0) begin
         checks++;
         $display("FAIL drain_timeout: %0d pending expected 0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
      a = 32'h1; b = 32'h1; sel = 6'h1C;
      w.name = "mid_add"; w.sel = sel; w.a = a; w.b = b; w.exp = 32'h2;
      exp_q.push_back(w);
      @(posedge clk);
      #3 reset = 1'b1;
      #1 check("mid_async_reset", result, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1 check("post_reset_add", result, 32'h2);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/ri_type.md
Name: ri_type

Overview:
- Integer ALU for RV32I register-register (R-type) and register-immediate (I-type) arithmetic, logic, shift and compare instructions.
- Sits in the decode/execute path. Operand `b` arrives already resolved: rs2 for R-type, or the sign-extended 32-bit immediate for I-type.
- A 6-bit `aluSelect` code chooses the operation. The result is registered, giving one-cycle latency.

Parameters:
- None. Data width is fixed at 32 bits and the select code is fixed at 6 bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- a  input  32  operand A (rs1)
- b  input  32  operand B (rs2 or sign-extended immediate)
- aluSelect  input  6  operation select code
- result  output  32  registered ALU result

Behaviour:
- Reset: asynchronous and active-high. While `reset`=1, `result`=32'h0000_0000 immediately, with no clock needed. The first update after reset deasserts happens on the next rising `clk`.
- Latency: the combinational result f(a, b, aluSelect) is captured into `result` on every rising `clk`. `result` reflects the inputs sampled at the previous edge. No enable and no handshake.
- Operation codes (hex), with R-type and I-type pairs computing identically:
  - 13 ADDI, 1C ADD: a + b, modulo 2^32, no overflow flag.
  - 1D SUB: a − b, modulo 2^32.
  - 14 ANDI, 1E AND: a & b.
  - 15 ORI, 1F OR: a | b.
  - 16 XORI, 20 XOR: a ^ b.
  - 17 SLLI, 21 SLL: a << b[4:0].
  - 18 SRLI, 22 SRL: a >> b[4:0], zero fill.
  - 19 SRAI, 23 SRA: a >>> b[4:0], sign fill from a[31].
  - 1A SLTI, 24 SLT: 1 if $signed(a) < $signed(b), else 0. Zero-extended to 32 bits.
  - 1B SLTIU, 25 SLTU: 1 if a < b unsigned, else 0. Zero-extended to 32 bits.
- Shift rules:
  - Only b[4:0] is used; b[31:5] are ignored.
  - A shift amount of 0 returns `a` unchanged.
  - A shift amount of 31 is valid (SRA of a negative value gives 0xFFFFFFFF).
- Any code not listed above (00–12, 26–3F) produces result 0. No X propagation; the output is fully defined for all 64 codes.
- Compare boundaries:
  - a == b gives 0 for both SLT and SLTU.
  - a=0x80000000, b=0x00000001: SLT=1, SLTU=0.
- If reset asserts mid-stream, the output clears at once. The pipeline holds no other state.

Test Plan:
- Reset: assert `reset` with a=0xFFFFFFFF, b=0x1, sel=1C and clock running → result=0 asynchronously. Deassert; one edge later → result=0x00000000 (wrap-around add).
- Sweep: a=0x000000F0, b=0x0000000F, codes 13..25, one edge each → expected results:
  - ADD(I) 0xFF
  - SUB 0xE1
  - AND(I) 0x0
  - OR(I) 0xFF
  - XOR(I) 0xFF
  - SLL(I) 0x00780000
  - SRL(I) 0x0
  - SRA(I) 0x0
  - SLT(I) 0
  - SLTU(I) 0
- Default: sel=3F with any operands → result=0. Also check sel=00 and sel=26 → result=0.
- Signed shifts: a=0x80000000, b=0x0000001F:
  - SRA → 0xFFFFFFFF
  - SRL → 0x00000001
  - SLL with b=0x00000021 (only b[4:0]=1 used) → 0x00000000
- Compares: a=0x80000000, b=0x00000001 → SLT=1, SLTU=0. a=b=0x12345678 → SLT=0, SLTU=0.
- Latency: change operands every cycle → each result appears exactly one rising edge after its inputs are sampled.
